// File: rtl/filt_chan_sched.sv
// Round-robin scheduler sharing one filters engine between NCH sample channels.
// Optional WAIT watchdog enabled by defining FILT_SCHED_TIMEOUT_EN.
module filt_chan_sched #(
  parameter int NCH       = 4,
  parameter int DATA_SIZE = 16,
  parameter int TIMEOUT   = 1023
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [NCH-1:0]           req_valid,
  input  logic [NCH*DATA_SIZE-1:0] req_data,
  input  logic [NCH*2-1:0]         req_sel,
  input  logic [NCH-1:0]           ovr_clr,
  output logic                     filt_start,
  output logic [1:0]               filt_select,
  output logic [DATA_SIZE-1:0]     filt_val,
  input  logic                     filt_done,
  input  logic [DATA_SIZE-1:0]     filt_result,
  output logic [NCH-1:0]           res_valid,
  output logic [DATA_SIZE-1:0]     res_data,
  output logic [NCH-1:0]           overrun,
  output logic                     busy,
  output logic                     timeout
);

  localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_RESP
  } state_t;

  state_t               r_state;
  logic [NCH-1:0]       r_pend;
  logic [DATA_SIZE-1:0] r_slot_data [NCH];
  logic [1:0]           r_slot_sel  [NCH];
  logic [IW-1:0]        r_last;
  logic [IW-1:0]        r_idx;
  logic                 r_start_cnt;

  logic                 w_any;
  logic                 w_grant;
  logic [IW-1:0]        w_pick;
  logic [NCH-1:0]       w_grant_oh;

`ifdef FILT_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0]        r_wait_cnt;
`else
  // Watchdog absent: the port stays, permanently low.
  assign timeout = (TIMEOUT < 0);
`endif

  // First pending channel found when searching upward from last+1, wrapping.
  function automatic logic [IW-1:0] rr_pick(input logic [NCH-1:0] pend,
                                            input logic [IW-1:0]  last);
    int c;
    rr_pick = '0;
    for (int k = NCH; k >= 1; k--) begin
      c = int'(last) + k;
      if (c >= NCH) c = c - NCH;
      if (pend[c]) rr_pick = c[IW-1:0];
    end
  endfunction

  always_comb begin
    w_any      = |r_pend;
    w_grant    = (r_state == S_IDLE) && w_any;
    w_pick     = rr_pick(r_pend, r_last);
    w_grant_oh = '0;
    if (w_grant) w_grant_oh[w_pick] = 1'b1;
  end

  // A grant on the same edge as a new strobe frees the slot, so no overrun.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_pend  <= '0;
      overrun <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (req_valid[i]) begin
          r_pend[i] <= 1'b1;
          if (r_pend[i] && !w_grant_oh[i]) overrun[i] <= 1'b1;
          else if (ovr_clr[i])             overrun[i] <= 1'b0;
        end else begin
          if (w_grant_oh[i]) r_pend[i]  <= 1'b0;
          if (ovr_clr[i])    overrun[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NCH; i++) begin
      if (req_valid[i]) begin
        r_slot_data[i] <= req_data[i*DATA_SIZE +: DATA_SIZE];
        r_slot_sel[i]  <= req_sel[i*2 +: 2];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state     <= S_IDLE;
      r_last      <= IW'(NCH - 1);
      r_idx       <= '0;
      r_start_cnt <= 1'b0;
      filt_start  <= 1'b0;
      filt_select <= 2'b00;
      filt_val    <= '0;
      res_valid   <= '0;
      res_data    <= '0;
      busy        <= 1'b0;
`ifdef FILT_SCHED_TIMEOUT_EN
      r_wait_cnt  <= '0;
      timeout     <= 1'b0;
`endif
    end else begin
      res_valid <= '0;
`ifdef FILT_SCHED_TIMEOUT_EN
      timeout   <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_idx       <= w_pick;
            r_last      <= w_pick;
            filt_val    <= r_slot_data[w_pick];
            filt_select <= r_slot_sel[w_pick];
            filt_start  <= 1'b1;
            busy        <= 1'b1;
            r_start_cnt <= 1'b0;
            r_state     <= S_START;
          end
        end
        // Two cycles of start with done ignored, for the engine's start qualifier.
        S_START: begin
          if (r_start_cnt) begin
            r_state <= S_WAIT;
`ifdef FILT_SCHED_TIMEOUT_EN
            r_wait_cnt <= '0;
`endif
          end else begin
            r_start_cnt <= 1'b1;
          end
        end
        S_WAIT: begin
          if (filt_done) begin
            res_data         <= filt_result;
            res_valid[r_idx] <= 1'b1;
            filt_start       <= 1'b0;
            r_state          <= S_RESP;
          end
`ifdef FILT_SCHED_TIMEOUT_EN
          else if (r_wait_cnt == TW'(TIMEOUT - 1)) begin
            filt_start <= 1'b0;
            timeout    <= 1'b1;
            busy       <= 1'b0;
            r_state    <= S_IDLE;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
`endif
        end
        S_RESP: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          filt_start <= 1'b0;
          busy       <= 1'b0;
          r_state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule
